pc_fetch_redirect: RTL and testbench

Fetch-side PC sequencer for the RV32IM core. It consumes the execute-stage redirect outputs (branch taken, JALR target, pipeline hold), drives instruction-memory requests over a req/ready handshake, and presents fetched instructions to the IF/ID register. It also kills wrong-path work, discards stale responses after a redirect, and buffers one response when the pipeline is stalled.

---
 rtl/rv32im_pkg.sv | 21 ++
 rtl/fetch_skid_buffer.sv | 56 +++++
 rtl/pc_fetch_redirect.sv | 166 ++++++++++++++++
 tb/tb_pc_fetch_redirect.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// -----------------------------------------------------------------------------
// rv32im_pkg
// Shared types and constants for the RV32IM fetch front end.
//   fetch_state_e : fetch sequencer states (BOOT, FETCH, WAIT, KILL)
//   INSTR_BYTES   : PC step per sequential fetch
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), used as the idle
//                   contents of fetch-side holding registers
// -----------------------------------------------------------------------------
package rv32im_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      KILL  = 2'd3
   } fetch_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for a fetched instruction and its PC, used to
// park a response that arrives while the pipeline is stalled.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_i            : capture instr_i/pc_i (ignored while already full)
//   pop_i             : entry consumed this cycle; buffer empties
//   clear_i           : drop the entry (wrong-path kill); wins over load/pop
//   instr_i, pc_i     : data to capture
//   valid_o           : buffer holds an entry
//   instr_o, pc_o     : buffered instruction and its PC
// -----------------------------------------------------------------------------
module fetch_skid_buffer
   import rv32im_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  pop_i,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pc_o
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0] pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= DATA_WIDTH'(NOP_INSTR);
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i && !valid_q) begin
         // A full entry is never overwritten.
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end else if (pop_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_redirect.sv
// -----------------------------------------------------------------------------
// pc_fetch_redirect
// Fetch-side PC sequencer: issues instruction-memory requests over a
// req/ready handshake, applies execute-stage redirects (branch / JALR),
// kills wrong-path responses and parks one response during a stall.
// Optional build macro: PC_FETCH_MISALIGN_TRAP_EN -- a redirect target with
// bit[1] set raises misalign_o and leaves the PC untouched; without it the
// target is forced word aligned and the redirect proceeds.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   ex_valid_i, branch_taken_i,
//   branch_target_i, jalr_valid_i,
//   jalr_target_i                    : execute-stage redirect inputs
//   hold_pipeline_i, stall_i         : stall sources
//   imem_req_o, imem_addr_o,
//   imem_ready_i, imem_rdata_i       : instruction memory handshake
//   if_valid_o, if_instr_o, if_pc_o  : IF/ID write port
//   flush_o                          : kill IF/ID and ID/EX this edge
//   misalign_o                       : misaligned redirect target
// -----------------------------------------------------------------------------
module pc_fetch_redirect
   import rv32im_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid_i,
   input  logic                  branch_taken_i,
   input  logic [DATA_WIDTH-1:0] branch_target_i,
   input  logic                  jalr_valid_i,
   input  logic [DATA_WIDTH-1:0] jalr_target_i,
   input  logic                  hold_pipeline_i,
   input  logic                  stall_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_ready_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic                  if_valid_o,
   output logic [DATA_WIDTH-1:0] if_instr_o,
   output logic [DATA_WIDTH-1:0] if_pc_o,
   output logic                  flush_o,
   output logic                  misalign_o
);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] pend_q, pend_d;

   logic                  stall;
   logic                  redirect;
   logic                  misalign;
   logic [DATA_WIDTH-1:0] raw_target;
   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] redir_target;
   logic                  take_redirect;

   logic                  buf_valid, buf_load, buf_pop;
   logic [DATA_WIDTH-1:0] buf_instr, buf_pc;
   logic                  deliver;

   assign stall    = stall_i | hold_pipeline_i;
   assign redirect = ex_valid_i & (branch_taken_i | jalr_valid_i);

   // JALR wins over a branch; its target has bit 0 cleared.
   assign raw_target = jalr_valid_i ? (jalr_target_i & ~DATA_WIDTH'(1))
                                    : branch_target_i;
   assign target     = raw_target & ~DATA_WIDTH'(3);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
   assign misalign = redirect & raw_target[1];
`else
   assign misalign = 1'b0;
`endif

   // A misaligned redirect still flushes but leaves the PC where it was;
   // the trap unit supplies the real redirect later.
   assign take_redirect = redirect & ~misalign;
   assign redir_target  = misalign ? pc_q : target;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      imem_req_o = 1'b0;
      buf_load   = 1'b0;
      deliver    = 1'b0;
      unique case (state_q)
         BOOT: begin
            if (take_redirect) pc_d = target;
            state_d = FETCH;
         end
         FETCH, WAIT: begin
            // While the buffer is full no new request issues; WAIT is only
            // ever entered with the buffer empty.
            imem_req_o = (state_q == WAIT) | redirect | (~stall & ~buf_valid);
            if (redirect) begin
               if (imem_ready_i) begin
                  pc_d    = redir_target;
                  state_d = FETCH;
               end else begin
                  pend_d  = redir_target;
                  state_d = KILL;
               end
            end else if (imem_req_o) begin
               if (imem_ready_i) begin
                  pc_d    = pc_q + DATA_WIDTH'(INSTR_BYTES);
                  state_d = FETCH;
                  if (stall) buf_load = 1'b1;
                  else       deliver  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         KILL: begin
            // The old request must complete before the bus is reused; its
            // response is wrong-path and is dropped.
            imem_req_o = 1'b1;
            if (take_redirect) pend_d = target;
            if (imem_ready_i) begin
               pc_d    = take_redirect ? target : pend_q;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   assign buf_pop     = buf_valid & ~stall & ~redirect;
   assign if_valid_o  = ~redirect & (buf_pop | deliver);
   assign if_instr_o  = !if_valid_o ? '0 : (buf_pop ? buf_instr : imem_rdata_i);
   assign if_pc_o     = !if_valid_o ? '0 : (buf_pop ? buf_pc : pc_q);
   assign imem_addr_o = pc_q;
   assign flush_o     = redirect;
   assign misalign_o  = misalign;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   fetch_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (buf_load),
      .pop_i   (buf_pop),
      .clear_i (redirect),
      .instr_i (imem_rdata_i),
      .pc_i    (pc_q),
      .valid_o (buf_valid),
      .instr_o (buf_instr),
      .pc_o    (buf_pc)
   );

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_redirect
// Directed bench for pc_fetch_redirect. The instruction memory returns
// {16'hC0DE, addr[15:0]} unless an override word is selected.
// -----------------------------------------------------------------------------
module tb_pc_fetch_redirect;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, branch_taken, jalr_valid, hold_pipeline, stall;
   logic [31:0] branch_target, jalr_target;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid, flush, misalign;
   logic [31:0] if_instr, if_pc;
   logic        ovr_en;
   logic [31:0] ovr_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = ovr_en ? ovr_data : {16'hC0DE, imem_addr[15:0]};

   pc_fetch_redirect #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid_i      (ex_valid),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jalr_valid_i    (jalr_valid),
      .jalr_target_i   (jalr_target),
      .hold_pipeline_i (hold_pipeline),
      .stall_i         (stall),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ready_i    (imem_ready),
      .imem_rdata_i    (imem_rdata),
      .if_valid_o      (if_valid),
      .if_instr_o      (if_instr),
      .if_pc_o         (if_pc),
      .flush_o         (flush),
      .misalign_o      (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr_ex();
      ex_valid     = 1'b0;
      branch_taken = 1'b0;
      jalr_valid   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr_ex();
      branch_target = '0;
      jalr_target   = '0;
      hold_pipeline = 1'b0;
      stall         = 1'b0;
      imem_ready    = 1'b1;
      ovr_en        = 1'b0;
      ovr_data      = '0;

      // Reset state
      tick(); settle();
      chk("rst_req",      {31'd0, imem_req}, 32'd0);
      chk("rst_addr",     imem_addr,         32'h0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_flush",    {31'd0, flush},    32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_if_instr", if_instr,          32'h0);
      tick();
      rst = 1'b0; settle();
      chk("boot_req", {31'd0, imem_req}, 32'd0);

      // Sequential fetch, ready always high
      tick(); settle();
      chk("seq0_valid", {31'd0, if_valid}, 32'd1);
      chk("seq0_pc",    if_pc,             32'h0);
      chk("seq0_instr", if_instr,          32'hC0DE_0000);
      tick(); settle();
      chk("seq1_pc",    if_pc,             32'h4);
      tick(); settle();
      chk("seq2_pc",    if_pc,             32'h8);
      chk("seq2_instr", if_instr,          32'hC0DE_0008);

      // Taken branch to 0x100 with ready high
      tick();
      ex_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h100; settle();
      chk("br_flush",    {31'd0, flush},    32'd1);
      chk("br_if_valid", {31'd0, if_valid}, 32'd0);
      tick();
      clr_ex(); settle();
      chk("br_addr",  imem_addr,         32'h100);
      chk("br_valid", {31'd0, if_valid}, 32'd1);
      chk("br_pc",    if_pc,             32'h100);

      // Redirect to 0x200 while waiting; stale response must be dropped
      tick();
      imem_ready = 1'b0; settle();
      chk("w_req",  {31'd0, imem_req}, 32'd1);
      chk("w_addr", imem_addr,         32'h104);
      tick();
      ex_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; settle();
      chk("w_flush", {31'd0, flush},    32'd1);
      chk("w_req2",  {31'd0, imem_req}, 32'd1);
      tick();
      clr_ex(); settle();
      chk("kill_req",  {31'd0, imem_req}, 32'd1);
      chk("kill_addr", imem_addr,         32'h104);
      tick();
      imem_ready = 1'b1; settle();
      chk("kill_stale_valid", {31'd0, if_valid}, 32'd0);
      chk("kill_stale_addr",  imem_addr,         32'h104);
      tick(); settle();
      chk("kill_new_addr",  imem_addr,         32'h200);
      chk("kill_new_valid", {31'd0, if_valid}, 32'd1);
      chk("kill_new_pc",    if_pc,             32'h200);

      // Stall while a response returns at PC 0x8 -> skid buffer
      tick();
      ex_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h8; settle();
      chk("sk_br_flush", {31'd0, flush}, 32'd1);
      tick();
      clr_ex(); imem_ready = 1'b0; settle();
      chk("sk_req",  {31'd0, imem_req}, 32'd1);
      chk("sk_addr", imem_addr,         32'h8);
      tick();
      stall = 1'b1; imem_ready = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; settle();
      chk("sk_load_valid", {31'd0, if_valid}, 32'd0);
      chk("sk_load_req",   {31'd0, imem_req}, 32'd1);
      tick();
      imem_ready = 1'b0; ovr_en = 1'b0; settle();
      chk("sk_full_req",   {31'd0, imem_req}, 32'd0);
      chk("sk_full_valid", {31'd0, if_valid}, 32'd0);
      tick();
      stall = 1'b0; settle();
      chk("sk_pop_valid", {31'd0, if_valid}, 32'd1);
      chk("sk_pop_instr", if_instr,          32'hDEAD_BEEF);
      chk("sk_pop_pc",    if_pc,             32'h8);
      chk("sk_pop_req",   {31'd0, imem_req}, 32'd0);
      tick();
      imem_ready = 1'b1; settle();
      chk("sk_next_addr",  imem_addr, 32'hC);
      chk("sk_next_pc",    if_pc,     32'hC);
      chk("sk_next_instr", if_instr,  32'hC0DE_000C);

      // JALR to 0x303 together with a taken branch: JALR has priority
      tick();
      ex_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
      jalr_valid = 1'b1; jalr_target = 32'h303; settle();
      chk("jalr_flush",    {31'd0, flush},    32'd1);
      chk("jalr_if_valid", {31'd0, if_valid}, 32'd0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      chk("jalr_misalign", {31'd0, misalign}, 32'd1);
`else
      chk("jalr_misalign", {31'd0, misalign}, 32'd0);
`endif
      tick();
      clr_ex(); settle();
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      chk("jalr_addr", imem_addr, 32'h10);
`else
      chk("jalr_addr", imem_addr, 32'h300);
`endif

      // PC wrap at the top of the address space
      tick();
      ex_valid = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; settle();
      chk("wrap_flush", {31'd0, flush}, 32'd1);
      tick();
      clr_ex(); settle();
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc0",   if_pc,     32'hFFFF_FFFC);
      tick(); settle();
      chk("wrap_addr1", imem_addr, 32'h0);
      chk("wrap_pc1",   if_pc,     32'h0);

      // Hold pipeline acts as a stall: no request from FETCH
      tick();
      hold_pipeline = 1'b1; settle();
      chk("hold_req",   {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, if_valid}, 32'd0);
      hold_pipeline = 1'b0;

      // Reset in the middle of an outstanding request
      imem_ready = 1'b0; settle();
      chk("mr_req", {31'd0, imem_req}, 32'd1);
      tick();
      rst = 1'b1; settle();
      tick();
      rst = 1'b0; imem_ready = 1'b1; settle();
      chk("mr_boot_req",   {31'd0, imem_req}, 32'd0);
      chk("mr_boot_valid", {31'd0, if_valid}, 32'd0);
      chk("mr_boot_addr",  imem_addr,         32'h0);
      tick(); settle();
      chk("mr_addr",  imem_addr,         32'h0);
      chk("mr_valid", {31'd0, if_valid}, 32'd1);
      chk("mr_pc",    if_pc,             32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
